weight_fetch_ctrl: RTL and testbench

Read-side sequencer for the per-layer weight ROMs: on `start` it walks ROM row addresses 0..INPUT_NODES-1 and absorbs the ROM's one-cycle registered read latency. It streams each fetched row (OUTPUT_NODES packed weights) to the downstream MAC array over a valid/ready interface, with full backpressure support. It sits between the layer controller (start/done) and the neuron MAC bank.

---
 rtl/ann_pkg.sv | 13 +
 rtl/row_fifo.sv | 65 ++++++
 rtl/weight_fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared constants and FSM encoding for the ANN layer datapath.
package ann_pkg;

    localparam int unsigned ADDR_WIDTH      = 8;
    localparam int unsigned FETCH_BUF_DEPTH = 4;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t StIdle = 2'd0;
    localparam fsm_state_t StRun  = 2'd1;
    localparam fsm_state_t StDone = 2'd2;

endpackage

// File: rtl/row_fifo.sv
// Small synchronous FIFO holding fetched weight rows ({index, last, data}).
module row_fifo
    import ann_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [2:0]       count_o
);

    localparam int unsigned PtrW = $clog2(FETCH_BUF_DEPTH);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic [Width-1:0] mem_q [FETCH_BUF_DEPTH];
    logic [Width-1:0] mem_d [FETCH_BUF_DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head_o  = mem_q[rd_ptr_q];
        count_o = count_q;
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Walks weight ROM rows for one layer pass and streams them out over valid/ready,
// hiding the ROM's one-cycle read latency behind a credit-limited row FIFO.
module weight_fetch_ctrl
    import ann_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned INPUT_NODES  = 100,
    parameter int unsigned OUTPUT_NODES = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [ADDR_WIDTH-1:0]              mem_address,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] mem_weights,
    output logic                               row_valid,
    input  logic                               row_ready,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] row_data,
    output logic [ADDR_WIDTH-1:0]              row_index,
    output logic                               row_last
);

    localparam int unsigned RowWidth   = DATA_WIDTH * OUTPUT_NODES;
    localparam int unsigned EntryWidth = ADDR_WIDTH + 1 + RowWidth;

    fsm_state_t            state_q, state_d;
    logic [8:0]            iss_idx_q, iss_idx_d;
    logic                  iss_v_q, iss_v_d;
    logic                  rd_v_q, rd_v_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;

    logic                  issue;
    logic                  credit_ok;
    logic [3:0]            credit_sum;
    logic                  handshake;
    logic [2:0]            fifo_count;
    logic [EntryWidth-1:0] fifo_head;
    logic [EntryWidth-1:0] fifo_push_data;

    // Everything already buffered or still travelling through the ROM holds a slot.
    always_comb begin
        credit_sum = {1'b0, fifo_count} + {3'b000, iss_v_q} + {3'b000, rd_v_q};
        credit_ok  = credit_sum < 4'(FETCH_BUF_DEPTH);
        handshake  = row_valid && row_ready;
    end

    always_comb begin
        state_d       = state_q;
        iss_idx_d     = iss_idx_q;
        mem_address_d = mem_address_q;
        issue         = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StRun;
                    issue         = 1'b1;
                    mem_address_d = '0;
                    iss_idx_d     = 9'd1;
                end
            end
            StRun: begin
                if ((iss_idx_q < 9'(INPUT_NODES)) && credit_ok) begin
                    issue         = 1'b1;
                    mem_address_d = iss_idx_q[ADDR_WIDTH-1:0];
                    iss_idx_d     = iss_idx_q + 9'd1;
                end
                if (handshake && row_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        iss_v_d  = issue;
        rd_v_d   = iss_v_q;
        rd_idx_d = mem_address_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            iss_idx_q     <= '0;
            iss_v_q       <= 1'b0;
            rd_v_q        <= 1'b0;
            mem_address_q <= '0;
            rd_idx_q      <= '0;
        end else begin
            state_q       <= state_d;
            iss_idx_q     <= iss_idx_d;
            iss_v_q       <= iss_v_d;
            rd_v_q        <= rd_v_d;
            mem_address_q <= mem_address_d;
            rd_idx_q      <= rd_idx_d;
        end
    end

    always_comb begin
        fifo_push_data = {rd_idx_q, (rd_idx_q == ADDR_WIDTH'(INPUT_NODES - 1)), mem_weights};
    end

    row_fifo #(
        .Width(EntryWidth)
    ) u_row_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (rd_v_q),
        .push_data_i(fifo_push_data),
        .pop_i      (handshake),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    always_comb begin
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
        mem_address = mem_address_q;
        row_valid   = (fifo_count != 3'd0);
        {row_index, row_last, row_data} = fifo_head;
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl: registered ROM stand-in, row scoreboard,
// timing checks, backpressure, start filtering and mid-pass reset.
module tb_weight_fetch_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned IN = 100;
    localparam int unsigned ON = 32;
    localparam int unsigned RW = DW * ON;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [7:0]    mem_address;
    logic [RW-1:0] mem_weights;
    logic          row_valid;
    logic          row_ready;
    logic [RW-1:0] row_data;
    logic [7:0]    row_index;
    logic          row_last;

    always #5 clk = ~clk;

    weight_fetch_ctrl #(
        .DATA_WIDTH  (DW),
        .INPUT_NODES (IN),
        .OUTPUT_NODES(ON)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_address(mem_address),
        .mem_weights(mem_weights),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_index  (row_index),
        .row_last   (row_last)
    );

    // ROM contents: known reference words plus a hash for everything else.
    function automatic logic [31:0] rom_word(int unsigned r, int unsigned w);
        if (r == 0 && w == 0)  return 32'hbca08236;
        if (r == 0 && w == 31) return 32'h3cb1d563;
        if (r == 9 && w == 31) return 32'hbc70e9a9;
        return (r * 32'h9E3779B1) ^ (w * 32'h85EBCA77) ^ 32'h5bd1e995;
    endfunction

    function automatic logic [RW-1:0] rom_row(int unsigned r);
        logic [RW-1:0] v;
        v = '0;
        for (int w = 0; w < ON; w++) v[RW-1-DW*w -: DW] = rom_word(r, w);
        return v;
    endfunction

    always @(posedge clk) mem_weights <= rom_row(int'(mem_address));

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         hs_count = 0;
    int         done_cyc = 0;
    bit         done_flag = 1'b0;
    bit         timing_on = 1'b0;
    int         t_base = 0;
    int         t_rows = 0;
    bit         prev_stall = 1'b0;
    logic [RW-1:0] prev_data;
    logic [7:0] prev_idx;
    logic [7:0] sb[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(string tag, logic [RW-1:0] obs, logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed_lo=%h expected_lo=%h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic push_pass();
        for (int i = 0; i < IN; i++) sb.push_back(8'(i));
        hs_count = 0;
    endtask

    // Check the current cycle mid-period, then advance to just after the next edge.
    task automatic tick();
        logic [7:0] e;
        #1;
        if (prev_stall) begin
            chk("valid_hold", 64'(row_valid), 64'd1);
            chk("idx_hold", 64'(row_index), 64'(prev_idx));
            chk_row("data_hold", row_data, prev_data);
        end
        chk("fifo_bound", 64'(dut.fifo_count <= 3'd4), 64'd1);
        if (done) begin
            done_flag = 1'b1;
            done_cyc  = cyc;
        end
        if (row_valid && row_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("row_index", 64'(row_index), 64'(e));
                chk_row("row_data", row_data, rom_row(int'(e)));
                chk("row_last", 64'(row_last), 64'(e == 8'(IN - 1)));
                if (e == 8'd0) begin
                    chk("r0_w0", 64'(row_data[RW-1 -: 32]), 64'h bca08236);
                    chk("r0_w31", 64'(row_data[31:0]), 64'h3cb1d563);
                end
                if (e == 8'd9) chk("r9_w31", 64'(row_data[31:0]), 64'hbc70e9a9);
                if (timing_on && int'(e) < t_rows) chk("row_cycle", 64'(cyc), 64'(t_base + int'(e)));
            end
            hs_count++;
        end
        prev_stall = row_valid && !row_ready;
        prev_data  = row_data;
        prev_idx   = row_index;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_until_done(int budget, bit rnd);
        done_flag = 1'b0;
        for (int n = 0; n < budget && !done_flag; n++) begin
            if (rnd) row_ready = ($urandom_range(0, 9) < 3);
            tick();
        end
        chk("done_seen", 64'(done_flag), 64'd1);
    endtask

    int         c;
    int         max_a;
    bit         found;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        row_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(row_valid), 64'd0);
        chk("rst_addr", 64'(mem_address), 64'd0);

        // Full pass at full throughput with cycle-exact latency.
        row_ready = 1'b1;
        start     = 1'b1;
        c         = cyc;
        push_pass();
        timing_on = 1'b1;
        t_base    = c + 3;
        t_rows    = IN;
        tick();
        start = 1'b0;
        chk("addr_c1", 64'(mem_address), 64'd0);
        chk("busy_c1", 64'(busy), 64'd1);
        tick();
        chk("valid_c2", 64'(row_valid), 64'd0);
        run_until_done(300, 1'b0);
        timing_on = 1'b0;
        chk("done_cycle", 64'(done_cyc), 64'(c + 3 + IN));
        chk("rows_full", 64'(hs_count), 64'(IN));
        chk("busy_fall", 64'(busy), 64'd0);
        chk("done_pulse", 64'(done), 64'd0);

        // Start pulses during RUN must not restart the index.
        start = 1'b1;
        push_pass();
        tick();
        for (int i = 0; i < 40; i++) begin
            start = (i % 2 == 0);
            tick();
        end
        start = 1'b0;
        run_until_done(300, 1'b0);
        chk("rows_pulsed", 64'(hs_count), 64'(IN));
        chk("busy_fall2", 64'(busy), 64'd0);
        // Back-to-back start in the first idle cycle.
        start     = 1'b1;
        push_pass();
        timing_on = 1'b1;
        t_base    = cyc + 3;
        t_rows    = IN;
        tick();
        start = 1'b0;
        run_until_done(300, 1'b0);
        timing_on = 1'b0;
        chk("rows_b2b", 64'(hs_count), 64'(IN));

        // Random backpressure.
        start = 1'b1;
        push_pass();
        tick();
        start = 1'b0;
        run_until_done(2000, 1'b1);
        chk("rows_rand", 64'(hs_count), 64'(IN));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Ready held low: only four rows may be issued.
        row_ready = 1'b0;
        start     = 1'b1;
        push_pass();
        tick();
        start = 1'b0;
        max_a = 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (int'(mem_address) > max_a) max_a = int'(mem_address);
        end
        chk("stall_addr", 64'(mem_address), 64'd3);
        chk("stall_addr_max", 64'(max_a), 64'd3);
        chk("stall_valid", 64'(row_valid), 64'd1);
        chk("stall_no_hs", 64'(hs_count), 64'd0);
        row_ready = 1'b1;
        timing_on = 1'b1;
        t_base    = cyc;
        t_rows    = 4;
        run_until_done(300, 1'b0);
        timing_on = 1'b0;
        chk("rows_stall", 64'(hs_count), 64'(IN));

        // Reset at row 50 with reads in flight, then restart from row 0.
        start = 1'b1;
        push_pass();
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (row_valid && row_index == 8'd50) found = 1'b1;
            else tick();
        end
        chk("reached_row50", 64'(found), 64'd1);
        reset     = 1'b1;
        row_ready = 1'b0;
        tick();
        reset      = 1'b0;
        prev_stall = 1'b0;
        sb.delete();
        chk("mid_rst_valid", 64'(row_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_addr", 64'(mem_address), 64'd0);
        row_ready = 1'b1;
        start     = 1'b1;
        push_pass();
        timing_on = 1'b1;
        t_base    = cyc + 3;
        t_rows    = 1;
        tick();
        start = 1'b0;
        run_until_done(300, 1'b0);
        timing_on = 1'b0;
        chk("rows_after_rst", 64'(hs_count), 64'(IN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
